// File: rtl/rs232_avs_responder.sv
// rs232_avs_responder: Avalon-MM slave exposing the RS232 map with RX/TX byte FIFOs.
// Build option: define RS232_AVS_LOOPBACK_EN to route TX writes into the RX FIFO.
module rs232_avs_responder #(
  parameter int RX_DEPTH    = 16,
  parameter int TX_DEPTH    = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        avm_clk,
  input  logic        avm_rst_n,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  input  logic        rx_byte_valid,
  input  logic [7:0]  rx_byte_data,
  output logic        rx_byte_ready,
  output logic        tx_byte_valid,
  output logic [7:0]  tx_byte_data,
  input  logic        tx_byte_ready
);

  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        pop_q, pop_d;
  logic        push_q, push_d;
  logic [7:0]  wdata_q, wdata_d;

  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wp_q, rx_rp_q;
  logic [RAW:0]   rx_cnt_q;
  logic         rx_empty, rx_full;
  logic         rx_push, rx_pop;
  logic [7:0]   rx_wdata;

  logic bus_push, push_full;
  logic wr_tx, stall, go_ack;
  logic unused_ok;

  assign unused_ok = ^avs_writedata[31:8];

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == (RAW+1)'(RX_DEPTH));
  assign rx_pop   = (state_q == S_ACK) & pop_q;
  assign bus_push = (state_q == S_ACK) & push_q;

`ifdef RS232_AVS_LOOPBACK_EN
  logic unused_lb;
  assign unused_lb = tx_byte_ready | rx_byte_valid
                   | (^rx_byte_data);
  assign rx_byte_ready = 1'b0;
  assign rx_push       = bus_push;
  assign rx_wdata      = wdata_q;
  assign push_full     = rx_full;
  assign tx_byte_valid = 1'b0;
  assign tx_byte_data  = 8'h00;
`else
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wp_q, tx_rp_q;
  logic [TAW:0]   tx_cnt_q;
  logic           tx_full, tx_pop;

  assign rx_byte_ready = avm_rst_n & ~rx_full;
  assign rx_push       = rx_byte_valid & rx_byte_ready;
  assign rx_wdata      = rx_byte_data;
  assign tx_full       = (tx_cnt_q == (TAW+1)'(TX_DEPTH));
  assign push_full     = tx_full;
  assign tx_byte_valid = (tx_cnt_q != '0);
  assign tx_byte_data  = tx_mem[tx_rp_q];
  assign tx_pop        = tx_byte_valid & tx_byte_ready;

  // TX FIFO pointers and occupancy
  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (bus_push) tx_wp_q <= tx_wp_q + TAW'(1);
      if (tx_pop)   tx_rp_q <= tx_rp_q + TAW'(1);
      tx_cnt_q <= tx_cnt_q + (TAW+1)'(bus_push)
                           - (TAW+1)'(tx_pop);
    end
  end

  // TX FIFO storage
  always_ff @(posedge avm_clk) begin
    if (bus_push) tx_mem[tx_wp_q] <= wdata_q;
  end
`endif

  // RX FIFO pointers and occupancy
  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + RAW'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + RAW'(1);
      rx_cnt_q <= rx_cnt_q + (RAW+1)'(rx_push)
                           - (RAW+1)'(rx_pop);
    end
  end

  // RX FIFO storage
  always_ff @(posedge avm_clk) begin
    if (rx_push) rx_mem[rx_wp_q] <= rx_wdata;
  end

  // A TX write may only enter ACK once a slot is free
  assign wr_tx  = avs_write & ~avs_read & (avs_address == 5'h4);
  assign stall  = wr_tx & push_full;
  assign go_ack = ~stall & (avs_read | avs_write) &
                  (((state_q == S_IDLE) & (WAIT_CYCLES == 0)) |
                   ((state_q == S_WAIT) & (cnt_q == 4'd0)));

  // Next-state, wait counter and the snapshot taken entering ACK
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    pop_d   = pop_q;
    push_d  = push_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (avs_read | avs_write) begin
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else if (stall) begin
            state_d = S_WAIT;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_ACK;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else if (go_ack)   state_d = S_ACK;
      end
      default: state_d = S_IDLE;
    endcase
    if (go_ack) begin
      rdata_d = '0;
      pop_d   = 1'b0;
      push_d  = wr_tx;
      wdata_d = avs_writedata[7:0];
      if (avs_read) begin
        case (avs_address)
          5'h0: begin
            rdata_d[7:0] = rx_empty ? 8'h00 : rx_mem[rx_rp_q];
            pop_d        = ~rx_empty;
          end
          5'h8: begin
            rdata_d[7] = ~rx_empty;
            rdata_d[6] = ~push_full;
          end
          default: rdata_d = '0;
        endcase
      end
    end
  end

  // Control state registers
  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      pop_q   <= 1'b0;
      push_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
      wdata_q <= wdata_d;
    end
  end

  assign avs_readdata    = rdata_q;
  assign avs_waitrequest = ~((state_q == S_ACK) & avm_rst_n);

endmodule

// File: tb/tb_rs232_avs_responder.sv
// tb_rs232_avs_responder: directed bench for the RS232 Avalon responder.
// Default build exercises both FIFOs; loopback build covers TX-to-RX routing.
module tb_rs232_avs_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  addr;
  logic        rd, wr;
  logic [31:0] wdata, rdata;
  logic        waitreq;
  logic        rxv, rxr;
  logic [7:0]  rxd;
  logic        txv, txr;
  logic [7:0]  txd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rs232_avs_responder #(
    .RX_DEPTH(16), .TX_DEPTH(4), .WAIT_CYCLES(1)
  ) dut (
    .avm_clk(clk),
    .avm_rst_n(rst_n),
    .avs_address(addr),
    .avs_read(rd),
    .avs_write(wr),
    .avs_writedata(wdata),
    .avs_readdata(rdata),
    .avs_waitrequest(waitreq),
    .rx_byte_valid(rxv),
    .rx_byte_data(rxd),
    .rx_byte_ready(rxr),
    .tx_byte_valid(txv),
    .tx_byte_data(txd),
    .tx_byte_ready(txr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (waitreq === 1'b1 && n < 64);
  endtask

  task automatic bus_read(input logic [4:0] a,
                          output logic [31:0] d,
                          output int n);
    @(negedge clk);
    rd = 1'b1;
    addr = a;
    wait_ack(n);
    d = rdata;
    rd = 1'b0;
  endtask

  task automatic bus_write(input logic [4:0] a,
                           input logic [7:0] b,
                           output int n);
    @(negedge clk);
    wr = 1'b1;
    addr = a;
    wdata = {24'hFFFFFF, b};
    wait_ack(n);
    wr = 1'b0;
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk);
    rxv = 1'b1;
    rxd = b;
    @(negedge clk);
    rxv = 1'b0;
  endtask

  logic [31:0] d;
  int n, lows;

  initial begin
    rst_n = 1'b0;
    addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
    rxv = 1'b0; rxd = '0; txr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_waitreq", {31'b0, waitreq}, 32'd1);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rxready", {31'b0, rxr}, 32'd0);
    chk("rst_txvalid", {31'b0, txv}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef RS232_AVS_LOOPBACK_EN
    chk("lb_rxready", {31'b0, rxr}, 32'd0);
    bus_read(5'h8, d, n);
    chk("lb_stat0", d, 32'h40);
    bus_write(5'h4, 8'h5A, n);
    chk("lb_wr_lat", n, 2);
    chk("lb_txvalid", {31'b0, txv}, 32'd0);
    bus_read(5'h8, d, n);
    chk("lb_stat1", d, 32'hC0);
    bus_read(5'h0, d, n);
    chk("lb_rx", d, 32'h5A);
    chk("lb_txvalid2", {31'b0, txv}, 32'd0);
    bus_read(5'h0, d, n);
    chk("lb_empty", d, 32'h0);
    bus_read(5'h8, d, n);
    chk("lb_stat2", d, 32'h40);
`else
    chk("rxready_up", {31'b0, rxr}, 32'd1);
    bus_read(5'h8, d, n);
    chk("stat_lat", n, 2);
    chk("stat_idle", d, 32'h40);

    rx_push(8'hA5);
    bus_read(5'h8, d, n);
    chk("stat_rx", d, 32'hC0);
    bus_read(5'h0, d, n);
    chk("rx_a5", d, 32'hA5);
    bus_read(5'h8, d, n);
    chk("stat_after", d, 32'h40);
    bus_read(5'h14, d, n);
    chk("unmapped", d, 32'h0);

    bus_write(5'h4, 8'h11, n);
    chk("wr_lat", n, 2);
    bus_write(5'h4, 8'h22, n);
    bus_write(5'h4, 8'h33, n);
    bus_write(5'h4, 8'h44, n);
    bus_read(5'h8, d, n);
    chk("stat_txfull", d, 32'h00);

    @(negedge clk);
    wr = 1'b1; addr = 5'h4; wdata = 32'h55;
    lows = 0;
    repeat (6) begin
      @(negedge clk);
      if (waitreq !== 1'b1) lows++;
    end
    chk("stall", lows, 0);
    chk("tx_head", {23'b0, txv, txd}, 32'h111);
    txr = 1'b1;
    @(negedge clk);
    chk("drain22", {23'b0, txv, txd}, 32'h122);
    chk("stall_p1", {31'b0, waitreq}, 32'd1);
    @(negedge clk);
    chk("drain33", {23'b0, txv, txd}, 32'h133);
    chk("ack_p2", {31'b0, waitreq}, 32'd0);
    wr = 1'b0;
    @(negedge clk);
    chk("drain44", {23'b0, txv, txd}, 32'h144);
    @(negedge clk);
    chk("drain55", {23'b0, txv, txd}, 32'h155);
    @(negedge clk);
    chk("drained", {31'b0, txv}, 32'd0);
    txr = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("fill_ready", {31'b0, rxr}, 32'd1);
      rxv = 1'b1;
      rxd = 8'h30 + 8'(i);
    end
    @(negedge clk);
    chk("full_ready", {31'b0, rxr}, 32'd0);
    rxd = 8'h40;
    bus_read(5'h0, d, n);
    chk("full_pop", d, 32'h30);
    @(negedge clk);
    chk("refill_ready", {31'b0, rxr}, 32'd1);
    @(negedge clk);
    chk("refull_ready", {31'b0, rxr}, 32'd0);
    rxv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus_read(5'h0, d, n);
      chk("wrap_order", d,
          (i == 15) ? 32'h40 : 32'h31 + 32'(i));
    end
    bus_read(5'h0, d, n);
    chk("empty_rd", d, 32'h0);
    bus_read(5'h8, d, n);
    chk("empty_stat", d, 32'h40);

    @(negedge clk);
    wr = 1'b1; addr = 5'h4; wdata = 32'h77;
    @(negedge clk);
    chk("rst_in_wait", {31'b0, waitreq}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_abort_wr", {31'b0, waitreq}, 32'd1);
    chk("rst_abort_tx", {31'b0, txv}, 32'd0);
    @(negedge clk);
    chk("rst_abort_tx2", {31'b0, txv}, 32'd0);
    rst_n = 1'b1;
    wait_ack(n);
    chk("restart_lat", n, 2);
    wr = 1'b0;
    @(negedge clk);
    chk("restart_tx", {23'b0, txv, txd}, 32'h177);
    txr = 1'b1;
    @(negedge clk);
    chk("restart_once", {31'b0, txv}, 32'd0);
    txr = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
